// File: rtl/ram_word_sequencer_pkg.sv
// Shared encodings for the word sequencer.
//   size_e  : core access size field (byte / half / word / illegal)
//   state_e : sequencer FSM states, also exported on the debug port
//   last_index() : index of the final byte lane for a given size
package ram_word_sequencer_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/ram_word_sequencer_if.sv
// Bus bundle for ram_word_sequencer: the core-side load/store port plus the
// byte-wide req/gnt port towards ram_controller.
//   slave  : view of the sequencer (accepts core requests, drives the RAM port)
//   master : view of the surroundings (core LSU and ram_controller)
// Handshakes:
//   core side : a request is taken in the cycle where req_i and gnt_o are both
//               high; gnt_o is only high while the sequencer is idle. Exactly one
//               rvalid_o pulse later reports completion (rdata_o / err_o valid
//               only in that cycle).
//   RAM side  : ram_req_o is held high with stable address/data until ram_gnt_i;
//               the byte is transferred in the gnt cycle and address/data move on
//               in the following cycle.
interface ram_word_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic              ram_ce_o;
  logic              ram_we_o;
  logic              ram_req_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i;
  logic              ram_gnt_i;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_rdata_i, ram_gnt_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output ram_ce_o, ram_we_o, ram_req_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_rdata_i, ram_gnt_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  ram_ce_o, ram_we_o, ram_req_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/ram_word_sequencer_load_extend.sv
// ram_load_extend: combinational load formatter.
//   data        : assembled little-endian bytes (byte i in data[8i+7:8i])
//   size        : access size (SZ_B / SZ_H / SZ_W)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend byte/half results
//   result      : 32-bit value returned to the core
module ram_load_extend
  import ram_word_sequencer_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (size)
      SZ_B:    result = {{24{~is_unsigned & data[7]}}, data[7:0]};
      SZ_H:    result = {{16{~is_unsigned & data[15]}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/ram_word_sequencer.sv
// ram_word_sequencer: turns one core load/store (byte/half/word) into 1, 2 or 4
// sequential byte transactions on ram_controller's req/gnt port, little-endian,
// and returns a single-cycle completion pulse with the formatted load data.
//   clk_i     : clock, all state on posedge
//   rst_ni    : asynchronous active-low reset
//   bus       : core port + RAM port (see ram_word_sequencer_if)
//   dbg_state : current FSM state
// Parameters:
//   ADDR_W        : byte-address width on both sides
//   MISALIGN_TRAP : 1 = misaligned LH/LW completes with err_o and no RAM access,
//                   0 = performed byte by byte like any other access
module ram_word_sequencer
  import ram_word_sequencer_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ram_word_sequencer_if.slave  bus,
  output state_e               dbg_state
);

  state_e            state;
  logic              we_q, unsigned_q;
  logic [1:0]        size_q, idx_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rbuf_q;

  logic              rvalid_q, err_q, ram_ce_q, ram_we_q, ram_req_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;

  logic              accept, illegal, misaligned, reject;
  logic [1:0]        idx_next;
  logic [31:0]       rbuf_next, load_result;

  assign accept     = bus.req_i && (state == IDLE);
  assign illegal    = (bus.size_i == SZ_X);
  // Only loads are checked for alignment; stores always go out bytewise.
  assign misaligned = !bus.we_i &&
                      (((bus.size_i == SZ_H) && bus.addr_i[0]) ||
                       ((bus.size_i == SZ_W) && (bus.addr_i[1:0] != 2'b00)));
  assign reject     = illegal || (MISALIGN_TRAP && misaligned);
  assign idx_next   = idx_q + 2'd1;

  // Buffer as it will look once the granted byte is captured, so the final
  // byte can be formatted in the same edge that raises rvalid.
  always_comb begin
    rbuf_next = rbuf_q;
    rbuf_next[{idx_q, 3'b000} +: 8] = bus.ram_rdata_i;
  end

  ram_load_extend u_load_extend (
    .data        (rbuf_next),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (load_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= 2'b00;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_req_q   <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q       <= bus.we_i;
            size_q     <= bus.size_i;
            unsigned_q <= bus.unsigned_i;
            addr_q     <= bus.addr_i;
            wdata_q    <= bus.wdata_i;
            idx_q      <= 2'd0;
            last_q     <= last_index(bus.size_i);
            rbuf_q     <= '0;
            if (reject) begin
              state    <= RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
            end else begin
              state       <= XFER;
              ram_ce_q    <= 1'b1;
              ram_req_q   <= 1'b1;
              ram_we_q    <= bus.we_i;
              ram_addr_q  <= bus.addr_i;
              ram_wdata_q <= bus.wdata_i[7:0];
            end
          end
        end
        XFER: begin
          if (bus.ram_gnt_i) begin
            rbuf_q <= rbuf_next;
            idx_q  <= idx_next;
            if (idx_q == last_q) begin
              state     <= RESP;
              ram_ce_q  <= 1'b0;
              ram_req_q <= 1'b0;
              ram_we_q  <= 1'b0;
              rvalid_q  <= 1'b1;
              rdata_q   <= we_q ? 32'd0 : load_result;
            end else begin
              // Address add wraps naturally at ADDR_W bits.
              ram_addr_q  <= addr_q + ADDR_W'(idx_next);
              ram_wdata_q <= wdata_q[{idx_next, 3'b000} +: 8];
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o       = accept;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.ram_ce_o    = ram_ce_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.ram_req_o   = ram_req_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wdata_o = ram_wdata_q;
  assign dbg_state       = state;

endmodule
